rv_instr_encoder: RTL and testbench

//  Encoder end of the RV32 control path: turns symbolic instruction requests (op, rd, rs1, rs2, imm)

---
 rtl/rv_pkg.sv | 45 ++++
 rtl/rv_field_pack.sv | 37 +++
 rtl/rv_instr_encoder.sv | 121 ++++++++++++
 tb/tb_rv_instr_encoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and encoding constants for the RV32 instruction encoder.
package rv_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_MUL   = 4'd6,
    OP_ADDI  = 4'd7,
    OP_ANDI  = 4'd8,
    OP_ORI   = 4'd9,
    OP_XORI  = 4'd10,
    OP_SLLI  = 4'd11,
    OP_LUI   = 4'd12,
    OP_CSRRW = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;

endpackage

// File: rtl/rv_field_pack.sv
// Combinational packer: op code plus register/immediate fields -> 32-bit RV32 word.
// o_legal is low for codes outside op_e; o_instr is then zero and must be ignored.
module rv_field_pack
  import rv_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [19:0] i_imm,
  output logic        o_legal,
  output logic [31:0] o_instr
);

  always_comb begin
    o_legal = 1'b1;
    o_instr = '0;
    case (i_op)
      OP_ADD:   o_instr = {F7_BASE, i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_SUB:   o_instr = {F7_SUB,  i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_AND:   o_instr = {F7_BASE, i_rs2, i_rs1, F3_AND, i_rd, OPC_OP};
      OP_OR:    o_instr = {F7_BASE, i_rs2, i_rs1, F3_OR,  i_rd, OPC_OP};
      OP_XOR:   o_instr = {F7_BASE, i_rs2, i_rs1, F3_XOR, i_rd, OPC_OP};
      OP_SLT:   o_instr = {F7_BASE, i_rs2, i_rs1, F3_SLT, i_rd, OPC_OP};
      OP_MUL:   o_instr = {F7_MUL,  i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_ADDI:  o_instr = {i_imm[11:0], i_rs1, F3_ADD, i_rd, OPC_OPIMM};
      OP_ANDI:  o_instr = {i_imm[11:0], i_rs1, F3_AND, i_rd, OPC_OPIMM};
      OP_ORI:   o_instr = {i_imm[11:0], i_rs1, F3_OR,  i_rd, OPC_OPIMM};
      OP_XORI:  o_instr = {i_imm[11:0], i_rs1, F3_XOR, i_rd, OPC_OPIMM};
      OP_SLLI:  o_instr = {F7_BASE, i_imm[4:0], i_rs1, F3_SLL, i_rd, OPC_OPIMM};
      OP_LUI:   o_instr = {i_imm[19:0], i_rd, OPC_LUI};
      OP_CSRRW: o_instr = {i_imm[11:0], i_rs1, F3_CSRRW, i_rd, OPC_SYSTEM};
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streams encoded RV32 words to instruction memory at sequential addresses.
// Holds the load FSM, address/count tracking and the single output register.
module rv_instr_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [19:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  enc_state_e        r_state, w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_instr;
  logic              r_valid, r_err;
  logic              w_legal, w_accept, w_emit, w_valid_nxt;
  logic [31:0]       w_instr;
  logic [ADDR_W:0]   w_issued;

  rv_field_pack u_pack (
    .i_op    (in_op),
    .i_rd    (in_rd),
    .i_rs1   (in_rs1),
    .i_rs2   (in_rs2),
    .i_imm   (in_imm),
    .o_legal (w_legal),
    .o_instr (w_instr)
  );

  // Words handed out so far: emitted ones plus the one parked in the output register.
  assign w_issued    = r_count + {{ADDR_W{1'b0}}, r_valid};
  assign w_emit      = r_valid & out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_valid_nxt = (w_accept & w_legal) | (r_valid & ~out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (finish || (r_count == DEPTH_C))
            w_state_nxt = w_valid_nxt ? ST_DRAIN : ST_DONE;
        end
        ST_DRAIN: begin
          if (!r_valid || out_ready) w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    done     = (r_state == ST_DONE);
    in_ready = (r_state == ST_LOAD) && (w_issued < DEPTH_C) && (!r_valid || out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= BASE_C;
      r_instr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_valid <= 1'b0;
      r_addr  <= BASE_C;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_emit) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
      if (w_accept && w_legal) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
      end else if (w_emit) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_instr = r_instr;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder (DEPTH=4 build so the full-load path is reachable).
module tb_rv_instr_encoder;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, finish = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [19:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [5:0]  out_addr;
  logic [31:0] out_instr;
  logic [6:0]  count;
  logic        busy, done, err;

  int          errors = 0;
  int          checks = 0;
  logic [37:0] sb[$];
  logic [5:0]  exp_addr = '0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .count(count), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [31:0] enc_model(input logic [3:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [19:0] imm);
    case (op)
      4'd0:  return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      4'd1:  return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      4'd2:  return {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
      4'd3:  return {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
      4'd4:  return {7'h00, rs2, rs1, 3'b100, rd, 7'h33};
      4'd5:  return {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
      4'd6:  return {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
      4'd7:  return {imm[11:0], rs1, 3'b000, rd, 7'h13};
      4'd8:  return {imm[11:0], rs1, 3'b111, rd, 7'h13};
      4'd9:  return {imm[11:0], rs1, 3'b110, rd, 7'h13};
      4'd10: return {imm[11:0], rs1, 3'b100, rd, 7'h13};
      4'd11: return {7'h00, imm[4:0], rs1, 3'b001, rd, 7'h13};
      4'd12: return {imm, rd, 7'h37};
      4'd13: return {imm[11:0], rs1, 3'b001, rd, 7'h73};
      default: return 32'h0;
    endcase
  endfunction

  // Each negedge with a handshake pending corresponds to exactly one word taken on the next rising edge.
  always @(negedge clk) begin
    if (!rst && !start && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got addr=%0d instr=%08h, none expected", out_addr, out_instr);
      end else begin
        logic [37:0] e;
        e = sb.pop_front();
        if ({out_addr, out_instr} !== e) begin
          errors++;
          $display("FAIL word: got addr=%0d instr=%08h, expected addr=%0d instr=%08h",
                   out_addr, out_instr, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    sb.delete();
    exp_addr = '0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [19:0] imm,
                      input logic [31:0] exp, input bit legal, output int waited);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    if (legal) begin
      sb.push_back({exp_addr, exp});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid === 1'b0) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: out_valid stayed %b, expected 0", out_valid);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: done stayed %b, expected 1", done);
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: %0d words outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_addr, out_instr, count, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%0d i=%08h c=%0d e=%b, expected all 0",
               out_valid, out_addr, out_instr, count, err);
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got rdy/busy/done=%b%b%b, expected 000", in_ready, busy, done);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready: got %b, expected 0", in_ready);
    end
  endtask

  task automatic test_add();
    int w;
    do_start();
    out_ready = 1'b1;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 1'b1, w);
    wait_drain();
    checks++;
    if (count !== 7'd1) begin
      errors++;
      $display("FAIL add_count: got %0d, expected 1", count);
    end
    check_sb_empty("add");
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    do_start();
    out_ready = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 20'd5, 32'h00500093, 1'b1, w1);
    send(OP_SUB,  5'd5, 5'd1, 5'd2, 20'd0, 32'h402082B3, 1'b1, w2);
    checks++;
    if (w1 + w2 != 0) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d stall cycles, expected 0", w1 + w2);
    end
    send(OP_LUI,  5'd7, 5'd0, 5'd0, 20'hABCDE, 32'hABCDE3B7, 1'b1, w1);
    wait_drain();
    checks++;
    if (count !== 7'd3) begin
      errors++;
      $display("FAIL b2b_count: got %0d, expected 3", count);
    end
    check_sb_empty("b2b");
  endtask

  task automatic test_formats();
    int w;
    do_start();
    out_ready = 1'b1;
    send(OP_LUI,  5'd7, 5'd0, 5'd0, 20'hABCDE, 32'hABCDE3B7, 1'b1, w);
    send(OP_SLLI, 5'd4, 5'd4, 5'd0, 20'd3,     32'h00321213, 1'b1, w);
    send(OP_MUL,  5'd6, 5'd1, 5'd2, 20'd0,     32'h02208333, 1'b1, w);
    wait_drain();
    checks++;
    if (count !== 7'd3 || out_addr !== 6'd3) begin
      errors++;
      $display("FAIL fmt_count: got count=%0d addr=%0d, expected 3/3", count, out_addr);
    end
    check_sb_empty("fmt");
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] e_b;
    do_start();
    out_ready = 1'b0;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 1'b1, w);
    e_b = enc_model(OP_ORI, 5'd2, 5'd1, 5'd0, 20'h000F0);
    in_op = OP_ORI; in_rd = 5'd2; in_rs1 = 5'd1; in_rs2 = 5'd0; in_imm = 20'h000F0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_addr, out_instr} !== {1'b1, 1'b0, 6'd0, 32'h002081B3}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b rdy=%b a=%0d i=%08h, expected v=1 rdy=0 a=0 i=002081b3",
                 out_valid, in_ready, out_addr, out_instr);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(OP_ORI, 5'd2, 5'd1, 5'd0, 20'h000F0, e_b, 1'b1, w);
    wait_drain();
    checks++;
    if (count !== 7'd2) begin
      errors++;
      $display("FAIL stall_count: got %0d, expected 2", count);
    end
    check_sb_empty("stall");
  endtask

  task automatic test_illegal();
    int w;
    do_start();
    out_ready = 1'b1;
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 1'b1, w);
    send(4'hF,    5'd9, 5'd9, 5'd9, 20'd0, 32'h0,        1'b0, w);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 20'd5, 32'h00500093, 1'b1, w);
    wait_drain();
    checks++;
    if (err !== 1'b1 || count !== 7'd2) begin
      errors++;
      $display("FAIL illegal_err: got err=%b count=%0d, expected 1/2", err, count);
    end
    check_sb_empty("illegal");
  endtask

  task automatic test_finish_drain();
    int w;
    do_start();
    checks++;
    if (err !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL start_clear: got err=%b count=%0d, expected 0/0", err, count);
    end
    out_ready = 1'b0;
    send(OP_XORI, 5'd8, 5'd7, 5'd0, 20'h00123, enc_model(OP_XORI, 5'd8, 5'd7, 5'd0, 20'h00123), 1'b1, w);
    #1 finish = 1'b1;
    @(posedge clk); #1 finish = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, out_valid} !== 4'b1001) begin
      errors++;
      $display("FAIL drain_state: got busy/done/rdy/v=%b%b%b%b, expected 1001",
               busy, done, in_ready, out_valid);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done();
    checks++;
    if ({busy, in_ready, count} !== {1'b0, 1'b0, 7'd1}) begin
      errors++;
      $display("FAIL finish_done: got busy=%b rdy=%b count=%0d, expected 0/0/1", busy, in_ready, count);
    end
    check_sb_empty("finish");
  endtask

  task automatic test_depth_fill();
    int w;
    do_start();
    out_ready = 1'b1;
    send(OP_ADD,   5'd3,  5'd1, 5'd2, 20'd0,    32'h002081B3, 1'b1, w);
    send(4'hE,     5'd0,  5'd0, 5'd0, 20'd0,    32'h0, 1'b0, w);
    send(OP_XOR,   5'd9,  5'd8, 5'd7, 20'd0,    enc_model(OP_XOR, 5'd9, 5'd8, 5'd7, 20'd0), 1'b1, w);
    send(OP_ANDI,  5'd10, 5'd9, 5'd0, 20'h7FF,  enc_model(OP_ANDI, 5'd10, 5'd9, 5'd0, 20'h7FF), 1'b1, w);
    send(OP_CSRRW, 5'd1,  5'd2, 5'd0, 20'h305,  enc_model(OP_CSRRW, 5'd1, 5'd2, 5'd0, 20'h305), 1'b1, w);
    in_valid = 1'b1; in_op = OP_ADD;
    wait_done();
    checks++;
    if ({done, in_ready, count, out_addr, err} !== {1'b1, 1'b0, 7'd4, 6'd4, 1'b1}) begin
      errors++;
      $display("FAIL full_done: got done=%b rdy=%b count=%0d addr=%0d err=%b, expected 1/0/4/4/1",
               done, in_ready, count, out_addr, err);
    end
    in_valid = 1'b0;
    check_sb_empty("full");
    do_start();
    @(negedge clk);
    checks++;
    if ({busy, done, err, count, out_addr} !== {1'b1, 1'b0, 1'b0, 7'd0, 6'd0}) begin
      errors++;
      $display("FAIL restart: got busy=%b done=%b err=%b count=%0d addr=%0d, expected 1/0/0/0/0",
               busy, done, err, count, out_addr);
    end
  endtask

  task automatic test_rst_mid();
    int w;
    do_start();
    out_ready = 1'b1;
    send(OP_SLT, 5'd4, 5'd5, 5'd6, 20'd0, enc_model(OP_SLT, 5'd4, 5'd5, 5'd6, 20'd0), 1'b1, w);
    send(4'hF,   5'd0, 5'd0, 5'd0, 20'd0, 32'h0, 1'b0, w);
    out_ready = 1'b0;
    send(OP_OR,  5'd1, 5'd2, 5'd3, 20'd0, enc_model(OP_OR, 5'd1, 5'd2, 5'd3, 20'd0), 1'b1, w);
    @(negedge clk);
    checks++;
    if ({out_valid, err, count} !== {1'b1, 1'b1, 7'd1}) begin
      errors++;
      $display("FAIL pre_rst: got v=%b err=%b count=%0d, expected 1/1/1", out_valid, err, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_addr, out_instr, count, err, in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_rst: got v=%b a=%0d i=%08h c=%0d e=%b rdy=%b busy=%b done=%b, expected all 0",
               out_valid, out_addr, out_instr, count, err, in_ready, busy, done);
    end
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL post_rst_idle: got busy=%b v=%b, expected 0/0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_formats();
    test_stall();
    test_illegal();
    test_finish_drain();
    test_depth_fill();
    test_rst_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
